// File: rtl/fb_coef_pkg.sv
// Shared constants and state encoding for the fB coefficient ROM streamer.
// FB_COEF_CHECKSUM_EN adds a running checksum of the streamed coefficients.
package fb_coef_pkg;

  localparam int unsigned FB_COEF_DW     = 16;
  localparam int unsigned FB_COEF_DEPTH  = 120;
  localparam int unsigned FB_COEF_AW     = 12;
  localparam int unsigned FB_COEF_CSUM_W = FB_COEF_DW + 4;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StFlush
  } fb_coef_state_e;

endpackage

// File: rtl/fb_coef_addr_wrap.sv
// Modulo-DEPTH pointer incrementer for the coefficient ROM address.
module fb_coef_addr_wrap #(
  parameter int unsigned WIDTH_A = 12,
  parameter int unsigned DEPTH   = 120
) (
  input  logic [WIDTH_A-1:0] ptr_i,
  output logic [WIDTH_A-1:0] ptr_next_o
);

  assign ptr_next_o = (ptr_i == WIDTH_A'(DEPTH - 1)) ? '0 : ptr_i + WIDTH_A'(1);

endmodule

// File: rtl/fb_coef_streamer.sv
// Reads a run of coefficients from the fB ROM and streams them over valid/ready.
// Define FB_COEF_CHECKSUM_EN to add the csum_o accumulator output.
module fb_coef_streamer
  import fb_coef_pkg::*;
#(
  parameter int unsigned WIDTH_A = FB_COEF_AW,
  parameter int unsigned DEPTH   = FB_COEF_DEPTH,
  parameter int unsigned DATA_W  = FB_COEF_DW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH_A-1:0] base_i,
  input  logic [WIDTH_A-1:0] len_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [WIDTH_A-1:0] rom_addr_o,
  input  logic [DATA_W-1:0]  rom_coef_i,
  output logic               m_valid_o,
  input  logic               m_ready_i,
  output logic [DATA_W-1:0]  m_data_o,
  output logic               m_last_o
`ifdef FB_COEF_CHECKSUM_EN
  ,
  output logic [DATA_W+3:0]  csum_o
`endif
);

  fb_coef_state_e     state_q;
  logic [WIDTH_A-1:0] ptr_q;
  logic [WIDTH_A-1:0] remaining_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic               m_valid_q;
  logic               m_last_q;
  logic [DATA_W-1:0]  m_data_q;

  logic [WIDTH_A-1:0] ptr_next;
  logic               base_bad;
  logic               start_ok;
  logic               load;
  logic               handshake;

  fb_coef_addr_wrap #(
    .WIDTH_A (WIDTH_A),
    .DEPTH   (DEPTH)
  ) u_addr_wrap (
    .ptr_i      (ptr_q),
    .ptr_next_o (ptr_next)
  );

  assign base_bad  = 32'(base_i) >= DEPTH;
  assign start_ok  = (state_q == StIdle) && start_i && !base_bad && (len_i != '0);
  // Refill the output register whenever it is empty or being drained this cycle.
  assign load      = (!m_valid_q || m_ready_i) && (remaining_q != '0);
  assign handshake = m_valid_q && m_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            if (base_bad) begin
              err_q <= 1'b1;
            end else if (len_i == '0) begin
              done_q <= 1'b1;
            end else begin
              ptr_q       <= base_i;
              remaining_q <= len_i;
              busy_q      <= 1'b1;
              state_q     <= StStream;
            end
          end
        end
        StStream: begin
          if (load) begin
            m_data_q    <= rom_coef_i;
            m_valid_q   <= 1'b1;
            m_last_q    <= (remaining_q == WIDTH_A'(1));
            ptr_q       <= ptr_next;
            remaining_q <= remaining_q - WIDTH_A'(1);
            if (remaining_q == WIDTH_A'(1)) begin
              state_q <= StFlush;
            end
          end
        end
        StFlush: begin
          if (handshake) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef FB_COEF_CHECKSUM_EN
  logic [DATA_W+3:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if (start_ok) begin
      csum_q <= '0;
    end else if (handshake) begin
      csum_q <= csum_q + {{4{m_data_q[DATA_W-1]}}, m_data_q};
    end
  end

  assign csum_o = csum_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign rom_addr_o = ptr_q;
  assign m_valid_o  = m_valid_q;
  assign m_last_o   = m_last_q;
  assign m_data_o   = m_data_q;

endmodule

// File: tb/tb_fb_coef_streamer.sv
// Scoreboard bench for fb_coef_streamer with a behavioural model of the fB ROM.
module tb_fb_coef_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] base;
  logic [11:0] len;
  logic        busy;
  logic        done;
  logic        err;
  logic [11:0] rom_addr;
  logic [15:0] rom_coef;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_last;
`ifdef FB_COEF_CHECKSUM_EN
  logic [19:0] csum;
`endif

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mon_e;
  int          n_checks = 0;
  int          n_errors = 0;
  int          done_cnt = 0;
  int          err_cnt  = 0;
  logic [19:0] exp_csum;
  logic        stall_prev;
  logic [15:0] data_prev;
  logic        last_prev;
  int          c0;
  int          e0;

  always #5 clk = ~clk;

  fb_coef_streamer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start),
    .base_i     (base),
    .len_i      (len),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .rom_addr_o (rom_addr),
    .rom_coef_i (rom_coef),
    .m_valid_o  (m_valid),
    .m_ready_i  (m_ready),
    .m_data_o   (m_data),
    .m_last_o   (m_last)
`ifdef FB_COEF_CHECKSUM_EN
    ,
    .csum_o     (csum)
`endif
  );

  function automatic logic [15:0] rom_val(input logic [11:0] a);
    case (a)
      12'd0:   rom_val = 16'h0066;
      12'd1:   rom_val = 16'hfef4;
      12'd2:   rom_val = 16'h0019;
      12'd5:   rom_val = 16'h0019;
      12'd6:   rom_val = 16'h0058;
      12'd10:  rom_val = 16'hffcf;
      12'd118: rom_val = 16'h00d3;
      12'd119: rom_val = 16'h0046;
      default: rom_val = {4'h3, a} ^ 16'h8a5c;
    endcase
  endfunction

  assign rom_coef = rom_val(rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int b, input int l);
    beat_t       bt;
    logic [15:0] d;
    exp_csum = '0;
    for (int i = 0; i < l; i++) begin
      d       = rom_val(12'((b + i) % 120));
      bt.data = d;
      bt.last = (i == l - 1);
      exp_q.push_back(bt);
      exp_csum = exp_csum + {{4{d[15]}}, d};
    end
    start = 1'b1;
    base  = 12'(b);
    len   = 12'(l);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c;
    int k;
    c = done_cnt;
    k = 0;
    while (done_cnt == c && k < budget) begin
      tick();
      k++;
    end
    check("done_seen", 32'(done_cnt - c), 32'd1);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", 32'(m_data), 32'(data_prev));
        check("hold_last", 32'(m_last), 32'(last_prev));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", m_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_data", 32'(m_data), 32'(mon_e.data));
          check("beat_last", 32'(m_last), 32'(mon_e.last));
        end
      end
      if (done) done_cnt++;
      if (err) err_cnt++;
      stall_prev = m_valid && !m_ready;
      data_prev  = m_data;
      last_prev  = m_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    base    = '0;
    len     = '0;
    m_ready = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_addr", 32'(rom_addr), 32'd0);
`ifdef FB_COEF_CHECKSUM_EN
    check("rst_csum", 32'(csum), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Back-to-back run with latency checks.
    m_ready = 1'b1;
    start_run(0, 3);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_valid_early", 32'(m_valid), 32'd0);
    check("t1_addr", 32'(rom_addr), 32'd0);
    tick();
    check("t1_valid", 32'(m_valid), 32'd1);
    check("t1_first", 32'(m_data), 32'h0066);
    tick();
    tick();
    check("t1_third", 32'(m_data), 32'h0019);
    check("t1_last", 32'(m_last), 32'd1);
    tick();
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_valid_end", 32'(m_valid), 32'd0);
    tick();
    check("t1_done_pulse", 32'(done), 32'd0);

    // Address wrap 119 -> 0.
    start_run(118, 4);
    wait_done(20);
`ifdef FB_COEF_CHECKSUM_EN
    check("t2_csum", 32'(csum), 32'h00073);
    tick();
    tick();
    check("t2_csum_hold", 32'(csum), 32'h00073);
`endif

    // Backpressure on the first beat.
    m_ready = 1'b0;
    start_run(5, 2);
    tick();
    check("t3_valid", 32'(m_valid), 32'd1);
    check("t3_first", 32'(m_data), 32'h0019);
    tick();
    tick();
    tick();
    check("t3_held", 32'(m_data), 32'h0019);
    check("t3_held_last", 32'(m_last), 32'd0);
    m_ready = 1'b1;
    wait_done(10);

    // len=0 and out-of-range base.
    c0    = done_cnt;
    e0    = err_cnt;
    start = 1'b1;
    base  = 12'd3;
    len   = 12'd0;
    tick();
    start = 1'b0;
    check("t4_done", 32'(done), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_valid", 32'(m_valid), 32'd0);
    tick();
    check("t4_done_pulse", 32'(done), 32'd0);
    start = 1'b1;
    base  = 12'd120;
    len   = 12'd5;
    tick();
    start = 1'b0;
    check("t4_err", 32'(err), 32'd1);
    check("t4_err_busy", 32'(busy), 32'd0);
    tick();
    check("t4_err_pulse", 32'(err), 32'd0);
    check("t4_err_valid", 32'(m_valid), 32'd0);
    check("t4_done_cnt", 32'(done_cnt - c0), 32'd1);
    check("t4_err_cnt", 32'(err_cnt - e0), 32'd1);

    // Reset mid-run, then restart.
    start_run(10, 8);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t5_valid", 32'(m_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_addr", 32'(rom_addr), 32'd0);
    c0 = done_cnt;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_no_replay", 32'(m_valid), 32'd0);
    start_run(10, 2);
    tick();
    check("t5_restart", 32'(m_data), 32'hffcf);
    wait_done(10);
    check("t5_done_cnt", 32'(done_cnt - c0), 32'd1);

    // Second start while busy is ignored.
    c0 = done_cnt;
    e0 = err_cnt;
    start_run(20, 5);
    tick();
    start = 1'b1;
    base  = 12'd50;
    len   = 12'd3;
    tick();
    start = 1'b0;
    wait_done(20);
    tick();
    tick();
    tick();
    check("t6_done_cnt", 32'(done_cnt - c0), 32'd1);
    check("t6_no_err", 32'(err_cnt - e0), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);

    // len > DEPTH keeps wrapping.
    start_run(0, 122);
    wait_done(200);
`ifdef FB_COEF_CHECKSUM_EN
    check("t7_csum", 32'(csum), 32'(exp_csum));
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fb_coef_streamer.md
Name: fb_coef_streamer

Overview:
- Read-side initiator for the fB coefficient ROM. It drives the ROM address port, samples the 16-bit signed coefficient, and streams a programmable run of coefficients to the butterfly datapath over a valid/ready interface.
- Replaces ad-hoc counter logic around each fB_sram_* instance.
- The ROM read is combinational, so the ROM output is registered in this block.

Parameters:
- WIDTH_A, 12: ROM address width.
- DEPTH, 120: number of valid ROM entries; the address wraps modulo DEPTH.
- DATA_W, 16: coefficient width, two's complement.

Ports:
- clk  in  1: single clock, rising edge.
- rst_n  in  1: reset, asynchronous, active-low.
- start  in  1: one-cycle request to begin a run; sampled only in IDLE.
- base  in  WIDTH_A: first ROM address of the run.
- len  in  WIDTH_A: number of coefficients to stream.
- busy  out  1: high from the accepted start until done.
- done  out  1: one-cycle pulse when the run completes.
- err  out  1: one-cycle pulse when start is rejected.
- rom_addr  out  WIDTH_A: address to the ROM.
- rom_coef  in  DATA_W: ROM data, combinational from rom_addr.
- m_valid  out  1: stream data valid.
- m_ready  in  1: downstream ready.
- m_data  out  DATA_W: coefficient.
- m_last  out  1: marks the final beat of the run.

Behaviour:
- Reset values: busy=0, done=0, err=0, m_valid=0, m_last=0, m_data=0, rom_addr=0, state=IDLE, remaining=0.
- States: IDLE, STREAM, FLUSH.
- IDLE, start=1:
  - base>=DEPTH: err pulses next cycle, no beats, stay IDLE.
  - len=0: done pulses next cycle, busy stays 0, no beats.
  - Otherwise: ptr<=base, remaining<=len, busy<=1, go to STREAM.
- rom_addr = ptr (registered). The ROM output is valid in the same cycle as rom_addr.
- STREAM load condition is (!m_valid || m_ready) with remaining>0. On load:
  - m_data<=rom_coef, m_valid<=1, m_last<=(remaining==1).
  - ptr<=(ptr==DEPTH-1)?0:ptr+1, remaining<=remaining-1.
  - When remaining reaches 0, go to FLUSH.
- FLUSH: on m_valid&&m_ready, m_valid<=0, m_last<=0, done<=1 for one cycle, busy<=0, go to IDLE.
- Throughput and latency:
  - 1 beat/cycle when m_ready is held high.
  - First m_valid appears 2 cycles after start (one cycle to load ptr, one to register data).
  - done appears 1 cycle after the last handshake.
- Handshake rules:
  - While m_valid&&!m_ready, m_data and m_last hold stable and ptr does not advance.
  - m_valid never drops without a handshake.
- start while busy: ignored, no err.
- rst_n low mid-run: all state is cleared immediately, the stream is abandoned with no done, and no beat is replayed after reset.
- len > DEPTH is legal: addresses keep wrapping and coefficients repeat.

Optional Feature:
- Macro: FB_COEF_CHECKSUM_EN.
- Defined:
  - Adds output port csum (DATA_W+4 bits), reset 0.
  - Cleared on an accepted start; accumulates sign-extended m_data on every handshake, wrapping modulo 2^(DATA_W+4).
  - Holds its final value from the done pulse until the next accepted start.
- Undefined: the port and the accumulator are absent; all other behaviour is identical.

Decomposition:
- Package fb_coef_pkg:
  - Constants FB_COEF_DW=16, FB_COEF_DEPTH=120, FB_COEF_AW=12.
  - State enum typedef (IDLE/STREAM/FLUSH).
  - Checksum width constant.
- One natural sub-module, fb_coef_addr_wrap: a modulo-DEPTH pointer incrementer. Everything else stays inline.

Test Plan:
- base=0, len=3, m_ready=1 -> beats 0x0066, 0xfef4, 0x0019 on consecutive cycles; m_last on the third beat; done 1 cycle later.
- base=118, len=4 -> 0x00d3, 0x0046, 0x0066, 0xfef4 (wrap 119->0); with FB_COEF_CHECKSUM_EN, csum=0x00073 (decimal 115).
- base=5, len=2, m_ready low 3 cycles on the first beat -> 0x0019 held stable, then 0x0058 with m_last; no beat lost or duplicated.
- start with len=0 -> done pulse next cycle, m_valid never rises. start with base=120 -> err pulse, busy stays 0.
- rst_n asserted after the 2nd beat of base=10, len=8 -> m_valid=0 and busy=0 immediately. A new start base=10 after reset restarts at 0xffcf.
- Second start pulse during an active run -> ignored; the stream continues uninterrupted and produces exactly one done.
